// File: rtl/synapse_scheduler.sv
// Time-shares one synaptic delay channel among N_PRE presynaptic inputs.
// Pending spikes are granted round-robin and emitted after a per-source configurable delay.
module synapse_scheduler #(
    parameter int unsigned N_PRE         = 4,
    parameter int unsigned DELAY_W       = 2,
    parameter int unsigned DEFAULT_DELAY = 3,
    parameter int unsigned DROP_W        = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [N_PRE-1:0]         spike_in,
    input  logic                     cfg_we,
    input  logic [$clog2(N_PRE)-1:0] cfg_idx,
    input  logic [DELAY_W-1:0]       cfg_delay,
    output logic                     spike_out,
    output logic [$clog2(N_PRE)-1:0] spike_src,
    output logic                     busy,
    output logic [DROP_W-1:0]        drop_count
);
    localparam int unsigned IdxW = $clog2(N_PRE);

    typedef enum logic [1:0] {StIdle, StDelay, StFire} state_e;

    state_e              state_q, state_d;
    logic [N_PRE-1:0]    pending_q, pending_d, grant_onehot;
    logic [DELAY_W-1:0]  delay_q [N_PRE];
    logic [DELAY_W-1:0]  cnt_q;
    logic [IdxW-1:0]     src_q, last_grant_q, gnt_idx, cand_idx;
    logic                gnt_found, grant, drop, spike_out_q;
    logic [DROP_W-1:0]   drop_q;

    // Round-robin search starting just after the last source that fired.
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        cand_idx  = '0;
        for (int unsigned k = 1; k <= N_PRE; k++) begin
            cand_idx = IdxW'((32'(last_grant_q) + k) % N_PRE);
            if (!gnt_found && pending_q[cand_idx]) begin
                gnt_found = 1'b1;
                gnt_idx   = cand_idx;
            end
        end
    end

    always_comb begin
        grant        = (state_q == StIdle) && gnt_found;
        grant_onehot = grant ? (N_PRE'(1) << gnt_idx) : '0;
        pending_d    = (pending_q & ~grant_onehot) | spike_in;
        // A spike on the index granted this edge simply re-latches, so it is not a drop.
        drop         = |(spike_in & pending_q & ~grant_onehot);
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (grant) state_d = StDelay;
            StDelay: if (cnt_q == '0) state_d = StFire;
            StFire:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= StIdle;
            pending_q    <= '0;
            cnt_q        <= '0;
            src_q        <= '0;
            last_grant_q <= IdxW'(N_PRE - 1);
            spike_out_q  <= 1'b0;
            drop_q       <= '0;
            for (int unsigned i = 0; i < N_PRE; i++) begin
                delay_q[i] <= DELAY_W'(DEFAULT_DELAY);
            end
        end else begin
            state_q     <= state_d;
            pending_q   <= pending_d;
            spike_out_q <= (state_q == StDelay) && (cnt_q == '0);
            if (grant) begin
                src_q <= gnt_idx;
                cnt_q <= delay_q[gnt_idx];
            end else if (state_q == StDelay && cnt_q != '0) begin
                cnt_q <= cnt_q - 1'b1;
            end
            if (state_q == StFire) begin
                last_grant_q <= src_q;
            end
            if (drop && drop_q != {DROP_W{1'b1}}) begin
                drop_q <= drop_q + 1'b1;
            end
            if (cfg_we && 32'(cfg_idx) < N_PRE) begin
                delay_q[cfg_idx] <= cfg_delay;
            end
        end
    end

    assign spike_out  = spike_out_q;
    assign spike_src  = src_q;
    assign busy       = (state_q != StIdle);
    assign drop_count = drop_q;

endmodule

// File: tb/tb_synapse_scheduler.sv
// Directed bench for synapse_scheduler: expected spikes (source, cycle) are queued when
// stimulus is driven and checked against spike_out by a negedge monitor.
module tb_synapse_scheduler;
    localparam int unsigned N_PRE = 4;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic [N_PRE-1:0] spike_in = '0;
    logic             cfg_we = 1'b0;
    logic [1:0]       cfg_idx = '0;
    logic [1:0]       cfg_delay = '0;
    logic             spike_out;
    logic [1:0]       spike_src;
    logic             busy;
    logic [7:0]       drop_count;

    typedef struct {
        int src;
        int cyc;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    bit   sb_en = 1'b1;
    int   c0;

    synapse_scheduler #(
        .N_PRE(4), .DELAY_W(2), .DEFAULT_DELAY(3), .DROP_W(8)
    ) dut (
        .clk(clk), .reset(reset), .spike_in(spike_in), .cfg_we(cfg_we),
        .cfg_idx(cfg_idx), .cfg_delay(cfg_delay), .spike_out(spike_out),
        .spike_src(spike_src), .busy(busy), .drop_count(drop_count)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (sb_en && spike_out === 1'b1) begin
            if (sb.size() == 0) begin
                check("unexpected_spike", 32'(spike_out), 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("spike_src", 32'(spike_src), e.src);
                check("fire_cycle", cyc, e.cyc);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        spike_in = '0;
        cfg_we   = 1'b0;
        reset    = 1'b1;
        step();
        reset    = 1'b0;
        sb.delete();
    endtask

    task automatic wait_drain(input int budget);
        for (int i = 0; i < budget && sb.size() != 0; i++) step();
        check("drain", sb.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state, then single spike on source 0 with default delay 3.
        do_reset();
        check("rst_spike_out", 32'(spike_out), 0);
        check("rst_spike_src", 32'(spike_src), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_drop", 32'(drop_count), 0);
        c0 = cyc;
        spike_in = 4'b0001;
        sb.push_back('{0, c0 + 6});
        step();
        spike_in = '0;
        check("busy_c1", 32'(busy), 0);
        for (int k = 2; k <= 7; k++) begin
            step();
            check($sformatf("busy_c%0d", k), 32'(busy), (k <= 6) ? 1 : 0);
        end
        wait_drain(20);

        // Zero delay on source 2.
        do_reset();
        cfg_we = 1'b1; cfg_idx = 2'd2; cfg_delay = 2'd0;
        step();
        cfg_we = 1'b0;
        c0 = cyc;
        spike_in = 4'b0100;
        sb.push_back('{2, c0 + 3});
        step();
        spike_in = '0;
        wait_drain(20);
        check("src_hold", 32'(spike_src), 2);

        // All four sources at once: round-robin 0..3, one grant every d+3 cycles.
        do_reset();
        c0 = cyc;
        spike_in = 4'b1111;
        for (int k = 0; k < 4; k++) sb.push_back('{k, c0 + 6 + 6 * k});
        step();
        spike_in = '0;
        wait_drain(60);
        check("rr_drop", 32'(drop_count), 0);
        check("rr_last_src", 32'(spike_src), 3);

        // Collision on pending source 1 while the channel is busy.
        do_reset();
        c0 = cyc;
        spike_in = 4'b0001;
        sb.push_back('{0, c0 + 6});
        step();
        spike_in = '0;
        step();
        spike_in = 4'b0010;
        step();
        spike_in = '0;
        step();
        spike_in = 4'b0010;
        step();
        spike_in = '0;
        check("drop_one", 32'(drop_count), 1);
        sb.push_back('{1, c0 + 12});
        wait_drain(30);
        check("drop_still_one", 32'(drop_count), 1);
        sb_en = 1'b0;
        spike_in = 4'b0010;
        repeat (400) step();
        spike_in = '0;
        check("drop_sat", 32'(drop_count), 255);
        step();
        check("drop_sat_hold", 32'(drop_count), 255);

        // Reset during DELAY aborts the spike and clears pending.
        do_reset();
        sb_en = 1'b1;
        spike_in = 4'b0010;
        step();
        spike_in = 4'b1000;
        step();
        spike_in = '0;
        check("mid_src", 32'(spike_src), 1);
        check("mid_busy", 32'(busy), 1);
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("abort_spike_out", 32'(spike_out), 0);
        check("abort_src", 32'(spike_src), 0);
        check("abort_busy", 32'(busy), 0);
        check("abort_drop", 32'(drop_count), 0);
        repeat (12) begin
            step();
            check("abort_idle", 32'(busy), 0);
        end

        // Config write during DELAY affects only the next grant.
        do_reset();
        c0 = cyc;
        spike_in = 4'b0001;
        sb.push_back('{0, c0 + 6});
        step();
        spike_in = '0;
        step();
        cfg_we = 1'b1; cfg_idx = 2'd0; cfg_delay = 2'd1;
        step();
        cfg_we = 1'b0;
        wait_drain(20);
        c0 = cyc;
        spike_in = 4'b0001;
        sb.push_back('{0, c0 + 4});
        step();
        spike_in = '0;
        wait_drain(20);

        // Write and grant of the same index on one edge: grant sees the old delay.
        do_reset();
        c0 = cyc;
        spike_in = 4'b0001;
        sb.push_back('{0, c0 + 6});
        step();
        spike_in = '0;
        cfg_we = 1'b1; cfg_idx = 2'd0; cfg_delay = 2'd0;
        step();
        cfg_we = 1'b0;
        wait_drain(20);
        c0 = cyc;
        spike_in = 4'b0001;
        sb.push_back('{0, c0 + 3});
        step();
        spike_in = '0;
        wait_drain(20);
        repeat (3) step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
